// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: one outstanding load/store with a fixed
// accept-to-response latency, byte/half/word lanes and access-fault detection.
module data_mem_ctrl #(
    parameter int          ADDR_W  = 12,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state,
    output logic        dbg_store_commit,
    output logic [31:0] dbg_log_pc,
    output logic [31:0] dbg_log_addr,
    output logic [31:0] dbg_log_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);
    localparam logic [33:0] SPAN     = 34'd1 << (ADDR_W + 2);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [2**ADDR_W];

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              fault;
    logic              commit;
    logic              store_commit;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [15:0]       lane_h;
    logic [31:0]       load_data;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_lane;
    logic [31:0]       merged;

    // Offset is taken with unsigned wrap, so addresses below BASE land out of range.
    always_comb begin
        off     = addr_q - BASE;
        idx     = off[ADDR_W+1:2];
        fault   = ({2'b00, off} >= SPAN)
                || (size_q == 2'b11)
                || (size_q == 2'b01 && addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
        rd_word = mem_q[idx];
        shifted = rd_word >> {addr_q[1:0], 3'b000};
        lane_h  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sext_q & lane_h[15]}}, lane_h};
            default: load_data = rd_word;
        endcase
        case (size_q)
            2'b00: begin
                wr_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                wr_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wr_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_mask = 32'hFFFF_FFFF;
                wr_lane = wdata_q;
            end
        endcase
        merged       = (rd_word & ~wr_mask) | (wr_lane & wr_mask);
        commit       = (state_q == BUSY) && (cnt_q == 2'd0);
        store_commit = commit && we_q && !fault;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    we_d    = req_we;
                    size_d  = req_size;
                    sext_d  = req_sext;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    rdata_d = (we_q || fault) ? 32'h0 : load_data;
                    err_d   = fault;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset wipes the whole array, which also discards any in-flight store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= 32'h0;
        end else if (store_commit) begin
            mem_q[idx] <= merged;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Store-log record is valid for exactly the commit cycle of a non-faulting store.
    assign dbg_state        = state_q;
    assign dbg_store_commit = store_commit;
    assign dbg_log_pc       = pc_q;
    assign dbg_log_addr     = {addr_q[31:2], 2'b00};
    assign dbg_log_data     = merged;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 12, meaning word-address width (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL take parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal values 1..4.
REQ-003 SHALL take parameter BASE, default 32'h0000_0000, meaning byte address of word 0; word-aligned.
REQ-004 SHALL use the port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL use the port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL use the port req_valid  input  1  request present.
REQ-007 SHALL use the port req_ready  output  1  block can accept a request.
REQ-008 SHALL use the port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL use the port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL use the port req_sext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-011 SHALL use the port req_addr  input  32  byte address.
REQ-012 SHALL use the port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL use the port req_pc  input  32  PC of the issuing instruction, used for the store log only.
REQ-014 SHALL use the port resp_valid  output  1  response present.
REQ-015 SHALL use the port resp_ready  input  1  consumer accepts the response.
REQ-016 SHALL use the port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-017 SHALL use the port resp_err  output  1  access fault (misaligned, out of range or illegal size).

Function
REQ-018 SHALL implement the FSM states IDLE, BUSY and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-019 SHALL, in IDLE, latch we, size, sext, addr, wdata and pc when req_valid=1 and enter BUSY with a counter loaded to LATENCY-1.
REQ-020 SHALL, in BUSY, decrement the counter each cycle; at 0, perform the access (commit cycle) and enter RESP, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL, in RESP, hold resp_rdata and resp_err stable until resp_valid & resp_ready, then return to IDLE; no new request is accepted in that same cycle.
REQ-022 SHALL compute the word index as (addr - BASE) >> 2 and flag out of range when (addr - BASE) >= 4*2^ADDR_W, evaluated with unsigned wrap.
REQ-023 SHALL flag misalignment for half with addr[0]=1 and for word with addr[1:0]!=0; size 11 SHALL also set the fault.
REQ-024 SHALL, on a faulted request, leave memory unmodified and return resp_err=1 with resp_rdata=0.
REQ-025 SHALL implement byte loads by selecting lane addr[1:0] and half loads by selecting lane addr[1], extended per sext; word loads return the full word and ignore sext.
REQ-026 SHALL implement stores by writing only the addressed byte or half lane at the commit edge, leaving the other lanes unchanged.
REQ-027 SHALL, on each committed store in simulation, print "@<pc 8 hex>: *<word addr 8 hex> <= <merged full word 8 hex>" with the word address byte-aligned to 4.
REQ-028 SHALL read memory at the commit cycle, so a load accepted after a store's response returns the stored data.

Reset
REQ-029 SHALL, while reset=1 at a rising edge, clear all memory words to 0, go to IDLE and drive req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-030 SHALL, when reset occurs during BUSY or RESP, abort the transaction: a pending store is not performed and no response is produced.
REQ-031 SHALL give reset priority over a simultaneous req_valid; the request is not accepted.

Verification
REQ-032 SHALL cover: with LATENCY=2, a word store of 0x1234_5678 to 0x10 followed by a word load of 0x10 -> each resp_valid comes 2 cycles after its accept, load rdata = 0x1234_5678, and the log shows "*00000010 <= 12345678".
REQ-033 SHALL cover: a byte store of 0xAB to 0x13 over 0x1234_5678, then lb of 0x13 and lbu of 0x13 -> word = 0xAB34_5678, lb = 0xFFFF_FFAB, lbu = 0x0000_00AB.
REQ-034 SHALL cover: a half store of 0x8001 to 0x22, then lh and lhu of 0x22 -> 0xFFFF_8001 and 0x0000_8001; lanes [15:0] unchanged.
REQ-035 SHALL cover: a word load of 0x12, a half store to 0x11, and a byte store to 4*2^ADDR_W -> resp_err=1, rdata=0, no log line, memory unchanged.
REQ-036 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0; a handshake then returns to IDLE.
REQ-037 SHALL cover: reset asserted in BUSY of a store to 0x40 -> no response, no log line, word 0x40 reads 0 afterward, req_ready=1 on the cycle after reset.
